uart_receiver: RTL

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: oversampled (16x) asynchronous serial receiver.
// Frame format: one start bit, DBIT data bits LSB-first, an optional even
// parity bit, and a stop bit counted over SB_TICK oversample strobes.
// Optional feature: define UART_RX_PARITY_EN to add the parity bit and
// the parity_err flag. Without it, parity_err is tied low.
module uart_receiver #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       s_tick,
  output logic [7:0] dout,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy,
  output logic       parity_err
);

  // Received bits enter at the MSB and move right. After DBIT shifts the
  // word sits in the top DBIT bits, so it is shifted down by SHIFT.
  localparam int         SHIFT    = 8 - DBIT;
  localparam logic [2:0] BIT_LAST = 3'(DBIT - 1);
  localparam logic [3:0] SB_LAST  = 4'(SB_TICK - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t     state_q, state_d;
  logic       rxMeta_q;
  logic       rxs_q;
  logic [3:0] tickCnt_q, tickCnt_d;
  logic [2:0] bitCnt_q, bitCnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] dout_q, dout_d;
  logic       rxDone_q, rxDone_d;
  logic       frameErr_q, frameErr_d;
  logic       armed_q, armed_d;
  logic [7:0] rxData;

`ifdef UART_RX_PARITY_EN
  logic       parityBit_q, parityBit_d;
  logic       parityErr_q, parityErr_d;
`endif

  assign rxData = shift_q >> SHIFT;

  // Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta_q <= 1'b1;
      rxs_q    <= 1'b1;
    end else begin
      rxMeta_q <= rx;
      rxs_q    <= rxMeta_q;
    end
  end

  // State, counters, shift register and the registered result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tickCnt_q  <= 4'd0;
      bitCnt_q   <= 3'd0;
      shift_q    <= 8'd0;
      dout_q     <= 8'd0;
      rxDone_q   <= 1'b0;
      frameErr_q <= 1'b0;
      armed_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
      parityBit_q <= 1'b0;
      parityErr_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tickCnt_q  <= tickCnt_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      dout_q     <= dout_d;
      rxDone_q   <= rxDone_d;
      frameErr_q <= frameErr_d;
      armed_q    <= armed_d;
`ifdef UART_RX_PARITY_EN
      parityBit_q <= parityBit_d;
      parityErr_q <= parityErr_d;
`endif
    end
  end

  // Next-state logic: every counter only moves on an s_tick, except the
  // start-edge detection in IDLE, which reacts to the line immediately.
  always_comb begin
    state_d    = state_q;
    tickCnt_d  = tickCnt_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    dout_d     = dout_q;
    rxDone_d   = 1'b0;
    frameErr_d = frameErr_q;
    armed_d    = armed_q;
`ifdef UART_RX_PARITY_EN
    parityBit_d = parityBit_q;
    parityErr_d = parityErr_q;
`endif
    unique case (state_q)
      IDLE: begin
        // After a framing error the line must go high before the next start,
        // so a held-low (break) line yields only one completed frame.
        if (!armed_q) begin
          if (rxs_q) begin
            armed_d = 1'b1;
          end
        end else if (!rxs_q) begin
          state_d   = START;
          tickCnt_d = 4'd0;
        end
      end
      START: begin
        if (s_tick) begin
          if (tickCnt_q == 4'd7) begin
            tickCnt_d = 4'd0;
            if (!rxs_q) begin
              state_d  = DATA;
              bitCnt_d = 3'd0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tickCnt_d = tickCnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tickCnt_q == 4'd15) begin
            tickCnt_d = 4'd0;
            shift_d   = {rxs_q, shift_q[7:1]};
            if (bitCnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bitCnt_d = bitCnt_q + 3'd1;
            end
          end else begin
            tickCnt_d = tickCnt_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (tickCnt_q == 4'd15) begin
            tickCnt_d   = 4'd0;
            parityBit_d = rxs_q;
            state_d     = STOP;
          end else begin
            tickCnt_d = tickCnt_q + 4'd1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (tickCnt_q == SB_LAST) begin
            tickCnt_d  = 4'd0;
            dout_d     = rxData;
            frameErr_d = ~rxs_q;
            armed_d    = rxs_q;
            rxDone_d   = 1'b1;
            state_d    = IDLE;
`ifdef UART_RX_PARITY_EN
            parityErr_d = (^rxData) != parityBit_q;
`endif
          end else begin
            tickCnt_d = tickCnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dout      = dout_q;
  assign rx_done   = rxDone_q;
  assign frame_err = frameErr_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parityErr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
